// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        DRAIN   = 2'b10,
        HALTED  = 2'b11
    } state_e;

    localparam int STALL_CNT_W = 16;

    // Saturating increment: the stall counter sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] v);
        return (v == '1) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX load and the ID instruction.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_BITS = 4
) (
    input  logic [REG_BITS-1:0] id_rs_i,
    input  logic [REG_BITS-1:0] id_rt_i,
    input  logic                id_use_rs_i,
    input  logic                id_use_rt_i,
    input  logic                ex_memread_i,
    input  logic [REG_BITS-1:0] ex_rd_i,
    output logic                lu_o
);

    // R0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lu_o = ex_memread_i && (ex_rd_i != '0) &&
                  ((id_use_rs_i && (id_rs_i == ex_rd_i)) ||
                   (id_use_rt_i && (id_rt_i == ex_rd_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: drives enables and flushes of every pipeline register.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_BITS     = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_BITS-1:0]    id_rs,
    input  logic [REG_BITS-1:0]    id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   ex_memread,
    input  logic [REG_BITS-1:0]    ex_rd,
    input  logic                   id_branch_taken,
    input  logic                   id_halt,
    input  logic                   mem_stall,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   halt,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                   mem_err_q, mem_err_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   lu;

    load_use_detect #(.REG_BITS(REG_BITS)) u_lu (
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_use_rs_i  (id_use_rs),
        .id_use_rt_i  (id_use_rt),
        .ex_memread_i (ex_memread),
        .ex_rd_i      (ex_rd),
        .lu_o         (lu)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // MEMWAIT behaves exactly like RUN once the memory is ready again, so both share one branch.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        halt        = 1'b0;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        wait_cnt_d  = '0;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            RUN, MEMWAIT: begin
                if (mem_stall) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    exmem_en   = 1'b0;
                    memwb_en   = 1'b0;
                    state_d    = MEMWAIT;
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
                end else if (lu) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    state_d    = RUN;
                end else if (id_halt) begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    ifid_flush = id_branch_taken;
                    state_d    = RUN;
                end
                if (!pc_en) begin
                    stall_cnt_d = satInc(stall_cnt_q);
                end
                if (wait_cnt_d == WAIT_MAX) begin
                    mem_err_d = 1'b1;
                end
            end
            DRAIN: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (mem_stall) begin
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                halt     = 1'b1;
            end
            default: state_d = RUN;
        endcase

        // While reset is held the pipeline must free-run regardless of hazard inputs.
        if (!rst) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            halt       = 1'b0;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int REG_BITS = 4;
    localparam int DRAIN    = 3;
    localparam int TIMEOUT  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [REG_BITS-1:0] id_rs, id_rt, ex_rd;
    logic                id_use_rs, id_use_rt, ex_memread;
    logic                id_branch_taken, id_halt, mem_stall;
    logic                pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic                ifid_flush, idex_flush, halt, mem_err;
    logic [15:0]         stall_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model: what the pipeline is doing, not how the controller encodes it.
    bit mDraining, mHalted, mErr;
    int mDrainDone, mConsecStalls, mStalls;
    logic [4:0] expEn;
    logic       expIfidFlush, expIdexFlush, expHalt;

    pipe_ctrl #(.REG_BITS(REG_BITS), .DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .id_branch_taken (id_branch_taken),
        .id_halt         (id_halt),
        .mem_stall       (mem_stall),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .halt            (halt),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit loadUse();
        if (!ex_memread || ex_rd == 0) return 1'b0;
        return (id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd);
    endfunction

    task automatic modelReset();
        mDraining     = 1'b0;
        mHalted       = 1'b0;
        mErr          = 1'b0;
        mDrainDone    = 0;
        mConsecStalls = 0;
        mStalls       = 0;
    endtask

    // Expected outputs, bit order of expEn: pc, ifid, idex, exmem, memwb.
    task automatic computeExpected();
        expEn = 5'b11111; expIfidFlush = 1'b0; expIdexFlush = 1'b0; expHalt = 1'b0;
        if (!rst) begin
            expEn = 5'b11111;
        end else if (mHalted) begin
            expEn = 5'b00000; expHalt = 1'b1;
        end else if (mDraining) begin
            expEn = mem_stall ? 5'b00000 : 5'b00111;
            expIfidFlush = 1'b1; expIdexFlush = 1'b1;
        end else if (mem_stall) begin
            expEn = 5'b00000;
        end else if (loadUse()) begin
            expEn = 5'b00111; expIdexFlush = 1'b1;
        end else if (id_halt) begin
            expEn = 5'b01111; expIfidFlush = 1'b1;
        end else if (id_branch_taken) begin
            expIfidFlush = 1'b1;
        end
    endtask

    task automatic modelAdvance();
        computeExpected();
        if (mHalted) begin
            return;
        end else if (mDraining) begin
            mConsecStalls = 0;
            if (!mem_stall) begin
                mDrainDone++;
                if (mDrainDone == DRAIN) begin
                    mDraining = 1'b0;
                    mHalted   = 1'b1;
                end
            end
        end else begin
            if (!expEn[4] && mStalls < 65535) mStalls++;
            if (mem_stall) begin
                mConsecStalls++;
                if (mConsecStalls >= TIMEOUT) mErr = 1'b1;
            end else begin
                mConsecStalls = 0;
                if (!loadUse() && id_halt) begin
                    mDraining  = 1'b1;
                    mDrainDone = 0;
                end
            end
        end
    endtask

    task automatic checkAll(input string phase);
        computeExpected();
        checkOutput({phase, ".en"}, {11'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {11'b0, expEn});
        checkOutput({phase, ".flush"}, {14'b0, ifid_flush, idex_flush}, {14'b0, expIfidFlush, expIdexFlush});
        checkOutput({phase, ".halt"}, {15'b0, halt}, {15'b0, expHalt});
        checkOutput({phase, ".mem_err"}, {15'b0, mem_err}, {15'b0, mErr});
        checkOutput({phase, ".stall_cnt"}, stall_cnt, 16'(mStalls));
    endtask

    task automatic applyStimulus(input logic [3:0] rs, input logic [3:0] rt, input bit urs, input bit urt,
                                 input bit mr, input logic [3:0] rd, input bit br, input bit hlt, input bit ms);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        ex_memread = mr; ex_rd = rd; id_branch_taken = br; id_halt = hlt; mem_stall = ms;
    endtask

    task automatic runCycle(input string phase);
        @(negedge clk);
        checkAll(phase);
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    // Called just after a rising edge: reset pulses asynchronously well away from both edges.
    task automatic pulseReset(input string phase);
        rst = 1'b0;
        #1;
        modelReset();
        checkAll(phase);
        #1;
        rst = 1'b1;
    endtask

    int burst = 0;

    initial begin
        rst = 1'b0;
        applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
        #2;
        modelReset();
        checkAll("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        runCycle("loaduse");
        applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        runCycle("loaduse_after");

        applyStimulus(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        runCycle("r0guard");

        applyStimulus(4'd5, 4'd2, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        runCycle("br_lu");
        applyStimulus(4'd5, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        runCycle("br_after");

        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) runCycle("memwait");
        mem_stall = 1'b0;
        runCycle("memresume");
        runCycle("memresume2");

        id_halt = 1'b1;
        runCycle("hlt_in_id");
        id_halt = 1'b0;
        runCycle("drain1");
        mem_stall = 1'b1;
        runCycle("drain_stall");
        mem_stall = 1'b0;
        for (int i = 0; i < 5; i++) runCycle("drain_halt");

        pulseReset("reset_halted");
        id_halt = 1'b1;
        runCycle("hlt2");
        id_halt = 1'b0;
        runCycle("drain_pre_reset");
        pulseReset("reset_drain");
        runCycle("after_reset");

        for (int c = 0; c < 3000; c++) begin
            if (mHalted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 79) == 0)) begin
                pulseReset("rand_reset");
            end
            if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 8);
            applyStimulus(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
                          burst > 0 || $urandom_range(0, 9) == 0);
            if (burst > 0) burst--;
            runCycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
